decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, flow-controlled RV32I decode stage. It is the next generation of the purely combinational decoder and sits between fetch and execute. It accepts {pc, insn} over a valid/ready handshake and produces fully decoded fields, a sign-extended immediate for every format, and an illegal-instruction flag. A 2-entry skid buffer lets ready_o be driven from a register, so it has no combinational path from ready_i.

Parameters:
DWIDTH, 32, instruction/immediate width; must be >= 32; immediate sign-extended to DWIDTH
AWIDTH, 32, program counter width
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with ready_o = ~valid_o | ready_i

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
pc_i  in  AWIDTH  fetch PC
insn_i  in  DWIDTH  fetched instruction
valid_i  in  1  upstream valid
ready_o  out  1  stage can accept
flush_i  in  1  discard all held and incoming instructions
valid_o  out  1  decoded bundle valid
ready_i  in  1  downstream accepts
pc_o  out  AWIDTH  PC of the bundle
insn_o  out  DWIDTH  raw instruction
opcode_o  out  7  insn[6:0]
fmt_o  out  3  format enum: R, I, S, B, U, J, BAD
rd_o / rs1_o / rs2_o  out  5 each  register IDs, gated per format
funct3_o  out  3  insn[14:12]
funct7_o  out  7  insn[31:25] for R-type and I-shifts, else 0
shamt_o  out  5  insn[24:20] for I-shifts, else 0
imm_o  out  DWIDTH  sign-extended immediate
illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (rst==0 at a clk edge): valid_o=0, ready_o=0, all data outputs 0, state EMPTY. First cycle after reset release: ready_o=1.
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i.
- Latency: 1 cycle from accepted input to valid_o when the stage is EMPTY. Throughput is 1/cycle with ready_i held high.
- States (SKID_EN=1):
  - EMPTY: on in, go to ONE.
  - ONE: in & ~out: capture into skid, go to FULL, ready_o<=0. in & out: output reg reloads, stay ONE. out & ~in: go to EMPTY.
  - FULL: on out, skid moves to the output reg, go to ONE, ready_o<=1. No input is accepted while FULL.
- Ordering is strictly FIFO. Output fields are stable while valid_o & ~ready_i.
- flush_i (registered effect): next state EMPTY, valid_o=0, ready_o=1. An input presented in the same cycle is dropped. flush_i has priority over in/out events.
- Field gating:
  - rd=0 for S/B.
  - rs1=0 for U/J.
  - rs2 nonzero only for R/S/B.
  - funct7 nonzero for R-type, and for OP-IMM with funct3 001 or 101.
- Immediates:
  - I: insn[31:20]
  - S: {insn[31:25], insn[11:7]}
  - B: {insn[31], insn[7], insn[30:25], insn[11:8], 0}
  - U: {insn[31:12], 12'b0}
  - J: {insn[31], insn[19:12], insn[20], insn[30:21], 0}
  - All formats sign-extended from insn[31]. R/BAD: 0.
- illegal_o=1 for any of:
  - insn[1:0] != 2'b11
  - unknown opcode (outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM)
  - OP with funct7 not in {0x00, 0x20}
  - OP-IMM shift with funct7 not in {0x00, 0x20}
- Illegal bundles still flow through with fmt=BAD, and rd/rs1/rs2/imm forced to 0.
- Decode is computed before the register, so output reg and skid both hold decoded bundles.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams
  - fmt_e enum
  - F3_SLL=3'b001 and F3_SR=3'b101
  - packed struct dec_bundle_t (pc, insn, fields, imm, fmt, illegal)
- One combinational sub-module, rv_decoder (insn -> dec_bundle_t), instantiated once ahead of the skid logic. The skid logic in decode_stage is type-agnostic over dec_bundle_t.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), pc=0x100, ready_i=1 -> next cycle valid_o=1, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, fmt=I, pc_o=0x100.
- srai x5,x6,3 (0x40335293) -> funct7=0x20, shamt=3, funct3=5, illegal=0. Repeat with funct7=0x10 -> illegal=1, fmt=BAD.
- sw x3,8(x4) (0x00322423) -> rd=0, rs1=4, rs2=3, imm=8, fmt=S.
- Backpressure: 3 back-to-back inputs A,B,C with ready_i=0 -> A and B accepted, ready_o=0 the cycle after B, C held. Release ready_i -> output order A,B,C with no loss or duplicate.
- flush_i asserted while FULL together with valid_i=1 -> next cycle valid_o=0, ready_o=1. Nothing from before the flush, including the input offered in the flush cycle, ever appears at the output.
- Reset asserted mid-stream while FULL -> next cycle all outputs 0, ready_o=0. After release, 0xFFFFFFFF decodes with illegal=1 in 1 cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
package decode_pkg;

  // Widest PC / instruction the bundle can carry; narrower parameters zero-extend.
  localparam int unsigned PC_MAX   = 64;
  localparam int unsigned INSN_MAX = 64;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtBad = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [PC_MAX-1:0]   pc;
    logic [INSN_MAX-1:0] insn;
    logic [6:0]          opcode;
    fmt_e                fmt;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          shamt;
    logic [INSN_MAX-1:0] imm;
    logic                illegal;
  } dec_bundle_t;

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: raw instruction -> gated fields and immediate.
module rv_decoder
  import decode_pkg::*;
(
  input  logic [PC_MAX-1:0]   pc,
  input  logic [INSN_MAX-1:0] insn,
  output dec_bundle_t         bundle
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       sgn;
  logic       is_shift;
  logic       f7_ok;
  logic       legal;
  fmt_e       fmt;
  logic [INSN_MAX-1:0] imm;

  // Classify the opcode, detect illegal encodings and build the immediate.
  always_comb begin
    op       = insn[6:0];
    f3       = insn[14:12];
    f7       = insn[31:25];
    sgn      = insn[31];
    is_shift = (op == OPC_OP_IMM) && ((f3 == F3_SLL) || (f3 == F3_SR));
    f7_ok    = (f7 == 7'h00) || (f7 == 7'h20);
    fmt      = FmtBad;
    legal    = 1'b1;
    imm      = '0;

    case (op)
      OPC_LUI, OPC_AUIPC: fmt = FmtU;
      OPC_JAL:            fmt = FmtJ;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM: fmt = FmtI;
      OPC_BRANCH:         fmt = FmtB;
      OPC_STORE:          fmt = FmtS;
      OPC_OP:             fmt = FmtR;
      default:            legal = 1'b0;
    endcase

    if (insn[1:0] != 2'b11) legal = 1'b0;
    if (((op == OPC_OP) || is_shift) && !f7_ok) legal = 1'b0;

    case (fmt)
      FmtI: imm = {{(INSN_MAX-12){sgn}}, insn[31:20]};
      FmtS: imm = {{(INSN_MAX-12){sgn}}, insn[31:25], insn[11:7]};
      FmtB: imm = {{(INSN_MAX-13){sgn}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      FmtU: imm = {{(INSN_MAX-32){sgn}}, insn[31:12], 12'b0};
      FmtJ: imm = {{(INSN_MAX-21){sgn}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase

    bundle.pc      = pc;
    bundle.insn    = insn;
    bundle.opcode  = op;
    bundle.fmt     = legal ? fmt : FmtBad;
    bundle.rd      = (legal && (fmt != FmtS) && (fmt != FmtB)) ? insn[11:7] : 5'd0;
    bundle.rs1     = (legal && (fmt != FmtU) && (fmt != FmtJ)) ? insn[19:15] : 5'd0;
    bundle.rs2     = (legal && ((fmt == FmtR) || (fmt == FmtS) || (fmt == FmtB))) ?
                     insn[24:20] : 5'd0;
    bundle.funct3  = f3;
    bundle.funct7  = ((op == OPC_OP) || is_shift) ? f7 : 7'd0;
    bundle.shamt   = is_shift ? insn[24:20] : 5'd0;
    bundle.imm     = legal ? imm : '0;
    bundle.illegal = ~legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, flow-controlled RV32I decode stage with optional 2-entry skid buffer.
// DWIDTH must be in [32, 64]; AWIDTH must be <= 64.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        fmt_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [PC_MAX-1:0]   pc_ext;
  logic [INSN_MAX-1:0] insn_ext;
  dec_bundle_t         dec;
  dec_bundle_t         out_q, out_d;
  dec_bundle_t         skid_q, skid_d;
  logic [1:0]          state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                xfer_in, xfer_out;

  // Widen inputs into the fixed-size bundle fields.
  always_comb begin
    pc_ext               = '0;
    pc_ext[AWIDTH-1:0]   = pc_i;
    insn_ext             = '0;
    insn_ext[DWIDTH-1:0] = insn_i;
  end

  rv_decoder u_dec (
    .pc     (pc_ext),
    .insn   (insn_ext),
    .bundle (dec)
  );

  assign valid_o  = (state_q != ST_EMPTY);
  // rdy_q also masks ready_o in the cycle right after reset in the non-skid build.
  assign ready_o  = SKID_EN ? rdy_q : (rdy_q & (~valid_o | ready_i));
  assign xfer_in  = valid_i & ready_o;
  assign xfer_out = valid_o & ready_i;

  // Occupancy FSM: output reg holds the head, skid holds the second entry.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          out_d = dec;
        end else if (xfer_in) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
    rdy_d = SKID_EN ? (state_d != ST_FULL) : 1'b1;
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign pc_o      = out_q.pc[AWIDTH-1:0];
  assign insn_o    = out_q.insn[DWIDTH-1:0];
  assign opcode_o  = out_q.opcode;
  assign fmt_o     = out_q.fmt;
  assign rd_o      = out_q.rd;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign funct3_o  = out_q.funct3;
  assign funct7_o  = out_q.funct7;
  assign shamt_o   = out_q.shamt;
  assign imm_o     = out_q.imm[DWIDTH-1:0];
  assign illegal_o = out_q.illegal;

  // Upper bundle bits beyond the configured widths are intentionally dropped.
  logic unused_out;
  assign unused_out = ^{out_q.pc, out_q.insn, out_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decoder predicts every accepted
// bundle, and outputs are compared in FIFO order as they leave the stage.
module tb_decode_stage;

  localparam int BW = 137;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, insn_i;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  fmt_o, funct3_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [BW-1:0] sb[$];

  always #5 clk = ~clk;

  decode_stage #(.DWIDTH(32), .AWIDTH(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .insn_i(insn_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .fmt_o(fmt_o), .rd_o(rd_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .shamt_o(shamt_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );

  // Reference decoder written per opcode; returns the packed expected output bundle.
  function automatic logic [BW-1:0] model(input logic [31:0] pc, input logic [31:0] ins);
    logic [6:0] op, f7, f7o;
    logic [2:0] f3, fmt;
    logic [4:0] rd, rs1, rs2, sh;
    logic [31:0] imm;
    logic ill;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    imm = 32'd0; f7o = 7'd0; sh = 5'd0; ill = 1'b0; fmt = 3'd6;
    case (op)
      7'h37, 7'h17: begin fmt = 3'd4; rs1 = 0; rs2 = 0; imm = {ins[31:12], 12'h000}; end
      7'h6F: begin
        fmt = 3'd5; rs1 = 0; rs2 = 0;
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67, 7'h03, 7'h0F, 7'h73: begin
        fmt = 3'd1; rs2 = 0; imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'h13: begin
        fmt = 3'd1; rs2 = 0; imm = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'd1 || f3 == 3'd5) begin
          f7o = f7; sh = ins[24:20];
          if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        end
      end
      7'h23: begin fmt = 3'd2; rd = 0; rs2 = ins[24:20]; imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h63: begin
        fmt = 3'd3; rd = 0;
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h33: begin fmt = 3'd0; f7o = f7; if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1; end
      default: ill = 1'b1;
    endcase
    if (ill) begin fmt = 3'd6; rd = 0; rs1 = 0; rs2 = 0; imm = 0; end
    return {pc, ins, op, fmt, rd, rs1, rs2, f3, f7o, sh, imm, ill};
  endfunction

  // One clock: sample at negedge (score outputs, record accepted inputs), then advance.
  task automatic step(output logic acc);
    logic [BW-1:0] got, exp;
    acc = 1'b0;
    @(negedge clk);
    got = {pc_o, insn_o, opcode_o, fmt_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, shamt_o,
           imm_o, illegal_o};
    if (!rst || flush_i) begin
      sb.delete();
    end else begin
      if (valid_o && ready_i) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got %h want none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_bundle got %h want %h", got, exp);
          end
        end
      end
      if (valid_i && ready_o) begin
        sb.push_back(model(pc_i, insn_i));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] ins);
    logic acc;
    acc = 1'b0;
    pc_i = pc; insn_i = ins; valid_i = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    valid_i = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_timeout got not accepted want accepted"); end
  endtask

  task automatic drain();
    logic acc;
    ready_i = 1'b1;
    for (int i = 0; i < 50 && (sb.size() != 0 || valid_o); i++) step(acc);
    checks++;
    if (sb.size() != 0 || valid_o) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    logic acc;
    rst = 1'b0;
    step(acc); step(acc);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready_o); end
    checks++;
    if ({pc_o, insn_o, imm_o, rd_o, rs1_o, rs2_o, fmt_o, illegal_o} !== '0) begin
      errors++; $display("FAIL rst_data got pc=%h imm=%h want 0", pc_o, imm_o);
    end
    rst = 1'b1;
    step(acc);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", ready_o); end
  endtask

  task automatic test_addi();
    ready_i = 1'b1;
    send(32'h100, 32'hFFF10093);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL addi_latency got %b want 1", valid_o); end
    checks++; if (rd_o !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", rd_o); end
    checks++; if (rs1_o !== 5'd2) begin errors++; $display("FAIL addi_rs1 got %0d want 2", rs1_o); end
    checks++; if (rs2_o !== 5'd0) begin errors++; $display("FAIL addi_rs2 got %0d want 0", rs2_o); end
    checks++; if (imm_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", imm_o); end
    checks++; if (fmt_o !== 3'd1) begin errors++; $display("FAIL addi_fmt got %0d want 1", fmt_o); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", pc_o); end
    drain();
  endtask

  task automatic test_shift();
    ready_i = 1'b1;
    send(32'h104, 32'h40335293);
    checks++; if (funct7_o !== 7'h20) begin errors++; $display("FAIL srai_f7 got %h want 20", funct7_o); end
    checks++; if (shamt_o !== 5'd3) begin errors++; $display("FAIL srai_shamt got %0d want 3", shamt_o); end
    checks++; if (funct3_o !== 3'd5) begin errors++; $display("FAIL srai_f3 got %0d want 5", funct3_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL srai_illegal got %b want 0", illegal_o); end
    drain();
    send(32'h108, 32'h20335293);
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL badshift_illegal got %b want 1", illegal_o); end
    checks++; if (fmt_o !== 3'd6) begin errors++; $display("FAIL badshift_fmt got %0d want 6", fmt_o); end
    checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL badshift_rd got %0d want 0", rd_o); end
    drain();
  endtask

  task automatic test_store();
    ready_i = 1'b1;
    send(32'h10C, 32'h00322423);
    checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL sw_rd got %0d want 0", rd_o); end
    checks++; if (rs1_o !== 5'd4) begin errors++; $display("FAIL sw_rs1 got %0d want 4", rs1_o); end
    checks++; if (rs2_o !== 5'd3) begin errors++; $display("FAIL sw_rs2 got %0d want 3", rs2_o); end
    checks++; if (imm_o !== 32'd8) begin errors++; $display("FAIL sw_imm got %h want 8", imm_o); end
    checks++; if (fmt_o !== 3'd2) begin errors++; $display("FAIL sw_fmt got %0d want 2", fmt_o); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int n0;
    n0 = n_out;
    ready_i = 1'b0;
    send(32'h200, 32'h00B50533);
    send(32'h204, 32'h123453B7);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", ready_o); end
    pc_i = 32'h208; insn_i = 32'hFFDFF0EF; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      checks++; if (acc) begin errors++; $display("FAIL bp_c_held got accepted want held"); end
    end
    checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL bp_stable got %h want 200", pc_o); end
    ready_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(acc);
    valid_i = 1'b0;
    checks++; if (!acc) begin errors++; $display("FAIL bp_c_accept got held want accepted"); end
    drain();
    checks++; if (n_out - n0 != 3) begin errors++; $display("FAIL bp_count got %0d want 3", n_out - n0); end
  endtask

  task automatic test_flush();
    logic acc;
    int n0;
    ready_i = 1'b0;
    send(32'h300, 32'h00B50533);
    send(32'h304, 32'h123453B7);
    pc_i = 32'h308; insn_i = 32'hFFDFF0EF; valid_i = 1'b1; flush_i = 1'b1;
    step(acc);
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", ready_o); end
    n0 = n_out;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);
    send(32'h30C, 32'h00000463);
    drain();
    checks++; if (n_out - n0 != 1) begin errors++; $display("FAIL flush_count got %0d want 1", n_out - n0); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    ready_i = 1'b0;
    send(32'h400, 32'h00B50533);
    send(32'h404, 32'h123453B7);
    rst = 1'b0;
    step(acc);
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL midrst_hs got v=%b r=%b want 0 0", valid_o, ready_o);
    end
    checks++; if ({pc_o, insn_o, imm_o, rd_o, rs1_o, rs2_o} !== '0) begin
      errors++; $display("FAIL midrst_data got pc=%h insn=%h want 0", pc_o, insn_o);
    end
    rst = 1'b1;
    step(acc);
    ready_i = 1'b1;
    send(32'h500, 32'hFFFFFFFF);
    checks++; if (valid_o !== 1'b1 || illegal_o !== 1'b1 || fmt_o !== 3'd6) begin
      errors++; $display("FAIL midrst_illegal got v=%b ill=%b fmt=%0d want 1 1 6", valid_o, illegal_o, fmt_o);
    end
    drain();
  endtask

  task automatic test_random();
    logic acc;
    logic [6:0] ops[12];
    int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h13};
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!valid_i || acc) begin
        valid_i = ($urandom_range(0, 3) != 0);
        pc_i = $urandom();
        k = $urandom_range(0, 13);
        insn_i = $urandom();
        if (k < 12) insn_i[6:0] = ops[k];
        if (k == 13) insn_i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      ready_i = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    valid_i = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    pc_i = 32'd0; insn_i = 32'd0;
    test_reset();
    test_addi();
    test_shift();
    test_store();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
